// File: rtl/ramio_arbiter_pkg.sv
// Shared types and helpers for the two-requester ramio arbiter.
// Tie-breaking is shaped by RAMIO_ARB_FIXED_PRIORITY_EN in the top module.
package ramio_arbiter_pkg;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Grant = 2'd1,
        Ack   = 2'd2
    } state_e;

    typedef logic requester_t;

    localparam int MaxDataBitWidth = 64;
    localparam logic [MaxDataBitWidth-1:0] ErrorData = '1;

    // On a tie the requester that did not win last time gets the port.
    function automatic requester_t pick_winner(
        input logic       req0,
        input logic       req1,
        input requester_t last_grant
    );
        requester_t winner;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req0) begin
            winner = 1'b0;
        end else begin
            winner = 1'b1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/ramio_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the ramio client port.
// The arbiter takes the slave view; requesters plus ramio together form the master view.
interface ramio_arbiter_if #(
    parameter int AddressBitWidth = 32,
    parameter int DataBitWidth    = 32
);

    logic                       rq0_req;
    logic [2:0]                 rq0_read_type;
    logic [1:0]                 rq0_write_type;
    logic [AddressBitWidth-1:0] rq0_address;
    logic [DataBitWidth-1:0]    rq0_data_in;
    logic [DataBitWidth-1:0]    rq0_data_out;
    logic                       rq0_ack;
    logic                       rq0_error;

    logic                       rq1_req;
    logic [2:0]                 rq1_read_type;
    logic [1:0]                 rq1_write_type;
    logic [AddressBitWidth-1:0] rq1_address;
    logic [DataBitWidth-1:0]    rq1_data_in;
    logic [DataBitWidth-1:0]    rq1_data_out;
    logic                       rq1_ack;
    logic                       rq1_error;

    logic                       io_enable;
    logic [2:0]                 io_read_type;
    logic [1:0]                 io_write_type;
    logic [AddressBitWidth-1:0] io_address;
    logic [DataBitWidth-1:0]    io_data_in;
    logic [DataBitWidth-1:0]    io_data_out;
    logic                       io_data_out_ready;
    logic                       io_busy;

    modport master (
        output rq0_req, rq0_read_type, rq0_write_type, rq0_address, rq0_data_in,
        input  rq0_data_out, rq0_ack, rq0_error,
        output rq1_req, rq1_read_type, rq1_write_type, rq1_address, rq1_data_in,
        input  rq1_data_out, rq1_ack, rq1_error,
        input  io_enable, io_read_type, io_write_type, io_address, io_data_in,
        output io_data_out, io_data_out_ready, io_busy
    );

    modport slave (
        input  rq0_req, rq0_read_type, rq0_write_type, rq0_address, rq0_data_in,
        output rq0_data_out, rq0_ack, rq0_error,
        input  rq1_req, rq1_read_type, rq1_write_type, rq1_address, rq1_data_in,
        output rq1_data_out, rq1_ack, rq1_error,
        output io_enable, io_read_type, io_write_type, io_address, io_data_in,
        input  io_data_out, io_data_out_ready, io_busy
    );

endinterface

// File: rtl/ramio_arbiter_watchdog.sv
// Per-transaction watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TimeoutCycles-th enabled cycle elapses. TimeoutCycles == 0 disables it.
module ramio_arbiter_watchdog #(
    parameter int TimeoutCycles   = 1024,
    parameter int TimeoutBitWidth = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int LimitInt = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
    localparam logic [TimeoutBitWidth-1:0] Limit = TimeoutBitWidth'(LimitInt);

    logic [TimeoutBitWidth-1:0] count_q;
    logic [TimeoutBitWidth-1:0] count_d;

    // Saturates at the limit so a stalled enable never wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != Limit)) begin
            count_d = count_q + TimeoutBitWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TimeoutCycles != 0) && enable_i && (count_q == Limit);

endmodule

// File: rtl/ramio_arbiter.sv
// Shares one ramio client port between two requesters (Idle -> Grant -> Ack per transaction).
// Define RAMIO_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of round-robin.
module ramio_arbiter
    import ramio_arbiter_pkg::*;
#(
    parameter int AddressBitWidth = 32,
    parameter int DataBitWidth    = 32,
    parameter int TimeoutCycles   = 1024,
    parameter int TimeoutBitWidth = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    ramio_arbiter_if.slave bus
);

    state_e                     state_q;
    requester_t                 grant_q;
    requester_t                 last_grant_q;
    requester_t                 grant_d;
    logic                       io_enable_q;
    logic                       rq0_ack_q;
    logic                       rq1_ack_q;
    logic                       rq0_error_q;
    logic                       rq1_error_q;
    logic [DataBitWidth-1:0]    rq0_data_q;
    logic [DataBitWidth-1:0]    rq1_data_q;
    logic [DataBitWidth-1:0]    rdata_d;

    logic [2:0]                 sel_read_type;
    logic [1:0]                 sel_write_type;
    logic [AddressBitWidth-1:0] sel_address;
    logic [DataBitWidth-1:0]    sel_data_in;
    logic                       any_req;
    logic                       done;
    logic                       expired;

    assign any_req = bus.rq0_req | bus.rq1_req;
    assign grant_d = pick_winner(bus.rq0_req, bus.rq1_req, last_grant_q);

    // Command follows the live inputs of the latched winner, even if its req drops.
    always_comb begin
        sel_read_type  = bus.rq0_read_type;
        sel_write_type = bus.rq0_write_type;
        sel_address    = bus.rq0_address;
        sel_data_in    = bus.rq0_data_in;
        if (grant_q) begin
            sel_read_type  = bus.rq1_read_type;
            sel_write_type = bus.rq1_write_type;
            sel_address    = bus.rq1_address;
            sel_data_in    = bus.rq1_data_in;
        end
    end

    assign done    = io_enable_q && !bus.io_busy &&
                     ((sel_read_type == 3'd0) || bus.io_data_out_ready);
    assign rdata_d = (sel_read_type != 3'd0) ? bus.io_data_out : '0;

    assign bus.io_enable     = io_enable_q;
    assign bus.io_read_type  = io_enable_q ? sel_read_type  : 3'd0;
    assign bus.io_write_type = io_enable_q ? sel_write_type : 2'd0;
    assign bus.io_address    = io_enable_q ? sel_address    : '0;
    assign bus.io_data_in    = io_enable_q ? sel_data_in    : '0;

    assign bus.rq0_ack      = rq0_ack_q;
    assign bus.rq0_error    = rq0_error_q;
    assign bus.rq0_data_out = rq0_data_q;
    assign bus.rq1_ack      = rq1_ack_q;
    assign bus.rq1_error    = rq1_error_q;
    assign bus.rq1_data_out = rq1_data_q;

    ramio_arbiter_watchdog #(
        .TimeoutCycles   (TimeoutCycles),
        .TimeoutBitWidth (TimeoutBitWidth)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == Idle),
        .enable_i  (state_q == Grant),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= Idle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            io_enable_q  <= 1'b0;
            rq0_ack_q    <= 1'b0;
            rq1_ack_q    <= 1'b0;
            rq0_error_q  <= 1'b0;
            rq1_error_q  <= 1'b0;
            rq0_data_q   <= '0;
            rq1_data_q   <= '0;
        end else begin
            rq0_ack_q   <= 1'b0;
            rq1_ack_q   <= 1'b0;
            rq0_error_q <= 1'b0;
            rq1_error_q <= 1'b0;
            case (state_q)
                Idle: begin
                    if (any_req) begin
                        state_q     <= Grant;
                        grant_q     <= grant_d;
                        io_enable_q <= 1'b1;
`ifndef RAMIO_ARB_FIXED_PRIORITY_EN
                        last_grant_q <= grant_d;
`endif
                    end
                end
                Grant: begin
                    // A real completion wins over a watchdog expiry in the same cycle.
                    if (done || expired) begin
                        state_q     <= Ack;
                        io_enable_q <= 1'b0;
                        if (grant_q) begin
                            rq1_ack_q   <= 1'b1;
                            rq1_error_q <= !done;
                            rq1_data_q  <= done ? rdata_d : ErrorData[DataBitWidth-1:0];
                        end else begin
                            rq0_ack_q   <= 1'b1;
                            rq0_error_q <= !done;
                            rq0_data_q  <= done ? rdata_d : ErrorData[DataBitWidth-1:0];
                        end
                    end
                end
                Ack: begin
                    state_q <= Idle;
                end
                default: begin
                    state_q     <= Idle;
                    io_enable_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
